// File: rtl/ice51_boot_loader.sv
// ice51_boot_loader: UART (8N1) boot loader for the ice51 core.
// The first MEM_SIZE received bytes are written sequentially into code memory
// from address 0 while the core is held in reset. After that the core is
// released and every further byte is forwarded as an rx_valid/rx_data pulse.
// Optional feature macro: ICE51_LOADER_CHECKSUM_EN. When it is defined, one
// extra byte after the image must equal the 8-bit modular sum of the image,
// otherwise o_err is set and loading restarts from address 0.
module ice51_boot_loader #(
  parameter int CLKS_PER_BIT = 104,
  parameter int MEM_SIZE     = 1024,
  parameter int ADDR_W       = 10
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_uart_rx,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  output logic              o_core_rst,
  output logic              o_done,
  output logic              o_err,
  output logic              o_rx_valid,
  output logic [7:0]        o_rx_data
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0]  C_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  // One extra count bit so MEM_SIZE == 2**ADDR_W never wraps.
  localparam logic [ADDR_W:0]   C_LAST_CNT  = (ADDR_W + 1)'(MEM_SIZE - 1);

  // ---------------------------------------------------------------- receiver
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic             r_rx_meta, r_rx_sync, r_rx_prev;
  rx_state_t        r_rx_state, w_rx_state_next;
  logic [CNT_W-1:0] r_clk_cnt, w_clk_cnt_next;
  logic [2:0]       r_bit_cnt, w_bit_cnt_next;
  logic [7:0]       r_shift, w_shift_next;
  logic             r_byte_valid, w_byte_valid_next;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge i_clk or posedge i_nrst) begin
    if (i_nrst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= i_uart_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge i_clk or posedge i_nrst) begin
    if (i_nrst) begin
      r_rx_state   <= RX_IDLE;
      r_clk_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
    end else begin
      r_rx_state   <= w_rx_state_next;
      r_clk_cnt    <= w_clk_cnt_next;
      r_bit_cnt    <= w_bit_cnt_next;
      r_shift      <= w_shift_next;
      r_byte_valid <= w_byte_valid_next;
    end
  end

  // Receiver next state: sample mid-bit, LSB first; the stop sample returns
  // straight to IDLE so a back-to-back start edge is not missed.
  always_comb begin
    w_rx_state_next   = r_rx_state;
    w_clk_cnt_next    = r_clk_cnt + 1'b1;
    w_bit_cnt_next    = r_bit_cnt;
    w_shift_next      = r_shift;
    w_byte_valid_next = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_clk_cnt_next = '0;
        if (r_rx_prev && !r_rx_sync) begin
          w_rx_state_next = RX_START;
          w_bit_cnt_next  = '0;
        end
      end
      RX_START: begin
        if (r_clk_cnt == C_HALF_LAST) begin
          w_clk_cnt_next  = '0;
          // A line back high at mid start bit was only a glitch.
          w_rx_state_next = r_rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_clk_cnt == C_BIT_LAST) begin
          w_clk_cnt_next = '0;
          w_shift_next   = {r_rx_sync, r_shift[7:1]};
          w_bit_cnt_next = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_rx_state_next = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (r_clk_cnt == C_BIT_LAST) begin
          w_clk_cnt_next    = '0;
          // Framing error (stop bit 0) drops the byte silently.
          w_byte_valid_next = r_rx_sync;
          w_rx_state_next   = RX_IDLE;
        end
      end
      default: begin
        w_rx_state_next = RX_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------ loader
`ifdef ICE51_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {LD_LOAD, LD_CHECK, LD_RUN} ld_state_t;
`else
  typedef enum logic [1:0] {LD_LOAD, LD_RUN} ld_state_t;
`endif

  ld_state_t         r_ld_state, w_ld_state_next;
  logic [ADDR_W:0]   r_count, w_count_next;
  logic              r_mem_we, w_mem_we_next;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_next;
  logic [7:0]        r_mem_wdata, w_mem_wdata_next;
  logic              r_core_rst, w_core_rst_next;
  logic              r_done, w_done_next;
  logic              r_rx_valid, w_rx_valid_next;
  logic [7:0]        r_rx_data, w_rx_data_next;
`ifdef ICE51_LOADER_CHECKSUM_EN
  logic [7:0]        r_sum, w_sum_next;
  logic              r_err, w_err_next;
`endif

  // Loader state and registered outputs.
  always_ff @(posedge i_clk or posedge i_nrst) begin
    if (i_nrst) begin
      r_ld_state  <= LD_LOAD;
      r_count     <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_core_rst  <= 1'b1;
      r_done      <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_rx_data   <= '0;
`ifdef ICE51_LOADER_CHECKSUM_EN
      r_sum       <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_ld_state  <= w_ld_state_next;
      r_count     <= w_count_next;
      r_mem_we    <= w_mem_we_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_core_rst  <= w_core_rst_next;
      r_done      <= w_done_next;
      r_rx_valid  <= w_rx_valid_next;
      r_rx_data   <= w_rx_data_next;
`ifdef ICE51_LOADER_CHECKSUM_EN
      r_sum       <= w_sum_next;
      r_err       <= w_err_next;
`endif
    end
  end

  // Loader next state: write image bytes, then (optionally) verify, then run.
  always_comb begin
    w_ld_state_next  = r_ld_state;
    w_count_next     = r_count;
    w_mem_we_next    = 1'b0;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_core_rst_next  = r_core_rst;
    w_done_next      = r_done;
    w_rx_valid_next  = 1'b0;
    w_rx_data_next   = r_rx_data;
`ifdef ICE51_LOADER_CHECKSUM_EN
    w_sum_next       = r_sum;
    w_err_next       = r_err;
`endif
    case (r_ld_state)
      LD_LOAD: begin
        if (r_byte_valid) begin
          w_mem_we_next    = 1'b1;
          w_mem_addr_next  = r_count[ADDR_W-1:0];
          w_mem_wdata_next = r_shift;
          w_count_next     = r_count + 1'b1;
`ifdef ICE51_LOADER_CHECKSUM_EN
          w_sum_next       = r_sum + r_shift;
          if (r_count == C_LAST_CNT) begin
            w_ld_state_next = LD_CHECK;
          end
`else
          if (r_count == C_LAST_CNT) begin
            w_ld_state_next = LD_RUN;
          end
`endif
        end
      end
`ifdef ICE51_LOADER_CHECKSUM_EN
      LD_CHECK: begin
        if (r_byte_valid) begin
          if (r_shift == r_sum) begin
            // Release the core in the cycle right after the checksum byte.
            w_ld_state_next = LD_RUN;
            w_err_next      = 1'b0;
            w_core_rst_next = 1'b0;
            w_done_next     = 1'b1;
          end else begin
            w_ld_state_next = LD_LOAD;
            w_err_next      = 1'b1;
            w_count_next    = '0;
            w_sum_next      = '0;
          end
        end
      end
`endif
      LD_RUN: begin
        // Entered together with the last write strobe, so the core is
        // released one cycle after that strobe.
        w_core_rst_next = 1'b0;
        w_done_next     = 1'b1;
        if (r_byte_valid) begin
          w_rx_valid_next = 1'b1;
          w_rx_data_next  = r_shift;
        end
      end
      default: begin
        w_ld_state_next = LD_LOAD;
      end
    endcase
  end

  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_core_rst  = r_core_rst;
  assign o_done      = r_done;
  assign o_rx_valid  = r_rx_valid;
  assign o_rx_data   = r_rx_data;
`ifdef ICE51_LOADER_CHECKSUM_EN
  assign o_err       = r_err;
`else
  assign o_err       = 1'b0;
`endif

endmodule

// File: tb/tb_ice51_boot_loader.sv
// Self-checking bench for ice51_boot_loader with a 4-byte image.
// Bits are driven with exact clock-cycle timing (104 cycles per bit).
module tb_ice51_boot_loader;

  localparam int CPB = 104;
  localparam int MEM = 4;
  localparam int AW  = 2;

  logic          clk = 1'b0;
  logic          nrst = 1'b1;
  logic          rx = 1'b1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          core_rst;
  logic          done;
  logic          err;
  logic          rx_valid;
  logic [7:0]    rx_data;

  ice51_boot_loader #(
    .CLKS_PER_BIT(CPB),
    .MEM_SIZE    (MEM),
    .ADDR_W      (AW)
  ) dut (
    .i_clk      (clk),
    .i_nrst     (nrst),
    .i_uart_rx  (rx),
    .o_mem_we   (mem_we),
    .o_mem_addr (mem_addr),
    .o_mem_wdata(mem_wdata),
    .o_core_rst (core_rst),
    .o_done     (done),
    .o_err      (err),
    .o_rx_valid (rx_valid),
    .o_rx_data  (rx_data)
  );

  always #42 clk = ~clk;

  // Monitor: counts strobes and remembers the last values seen on them.
  int         cyc = 0;
  int         we_cnt = 0;
  int         rxv_cnt = 0;
  int         last_we_cyc = 0;
  int         fall_cyc = -1;
  int         done_bad = 0;
  logic [AW-1:0] last_addr = '0;
  logic [7:0] last_wdata = '0;
  logic [7:0] last_rx = '0;
  logic       prev_core_rst = 1'b1;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mem_we) begin
      we_cnt      = we_cnt + 1;
      last_addr   = mem_addr;
      last_wdata  = mem_wdata;
      last_we_cyc = cyc;
    end
    if (rx_valid) begin
      rxv_cnt = rxv_cnt + 1;
      last_rx = rx_data;
    end
    if (prev_core_rst && !core_rst) fall_cyc = cyc;
    prev_core_rst = core_rst;
    if (done == core_rst) done_bad = done_bad + 1;
  end

  int n_pass = 0;
  int n_total = 0;
  int we_base = 0;
  int rxv_base = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total = n_total + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic mark();
    we_base  = we_cnt;
    rxv_base = rxv_cnt;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx   = 1'b1;
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    nrst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Sends one byte and checks it produced a single write at (addr, data).
  task automatic load_byte(input string name, input logic [7:0] d, input logic [AW-1:0] a);
    mark();
    send_frame(d, 1'b1);
    chk({name, "_we"},   32'(we_cnt - we_base), 32'd1);
    chk({name, "_addr"}, 32'(last_addr), 32'(a));
    chk({name, "_data"}, 32'(last_wdata), 32'(d));
  endtask

  typedef struct packed {
    logic [7:0]    data;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [7:0]    exp_wdata;
    logic          exp_rx;
    logic [7:0]    exp_rx_data;
    logic          exp_done;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vec_t v;
    // data, we, addr, wdata, rx, rx_data, done
    vecs.push_back('{8'h02, 1'b1, 2'd0, 8'h02, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{8'h00, 1'b1, 2'd1, 8'h00, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{8'h10, 1'b1, 2'd2, 8'h10, 1'b0, 8'h00, 1'b0});
`ifdef ICE51_LOADER_CHECKSUM_EN
    vecs.push_back('{8'hFF, 1'b1, 2'd3, 8'hFF, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{8'h11, 1'b0, 2'd3, 8'hFF, 1'b0, 8'h00, 1'b1});
`else
    vecs.push_back('{8'hFF, 1'b1, 2'd3, 8'hFF, 1'b0, 8'h00, 1'b1});
`endif
    vecs.push_back('{8'h5A, 1'b0, 2'd3, 8'hFF, 1'b1, 8'h5A, 1'b1});
    vecs.push_back('{8'hC3, 1'b0, 2'd3, 8'hFF, 1'b1, 8'hC3, 1'b1});

    // ---- reset values: reset held 1000 ns with the line idle
    rx   = 1'b1;
    nrst = 1'b1;
    #1000;
    chk("rst_mem_we",    32'(mem_we), 32'd0);
    chk("rst_mem_addr",  32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_core_rst",  32'(core_rst), 32'd1);
    chk("rst_done",      32'(done), 32'd0);
    chk("rst_err",       32'(err), 32'd0);
    chk("rst_rx_valid",  32'(rx_valid), 32'd0);
    chk("rst_rx_data",   32'(rx_data), 32'd0);
    @(negedge clk);
    nrst = 1'b0;
    repeat (4) @(negedge clk);

    // ---- table: image load, then post-boot forwarding
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      mark();
      send_frame(v.data, 1'b1);
      $display("vec %0d: sent 0x%02h we=%0d rx_valid=%0d done=%0d", i, v.data,
               we_cnt - we_base, rxv_cnt - rxv_base, done);
      chk($sformatf("v%0d_we_count", i), 32'(we_cnt - we_base), 32'(v.exp_we));
      if (v.exp_we) begin
        chk($sformatf("v%0d_addr", i),  32'(last_addr), 32'(v.exp_addr));
        chk($sformatf("v%0d_wdata", i), 32'(last_wdata), 32'(v.exp_wdata));
      end
      chk($sformatf("v%0d_rx_count", i), 32'(rxv_cnt - rxv_base), 32'(v.exp_rx));
      if (v.exp_rx) begin
        chk($sformatf("v%0d_rx_pulse_data", i), 32'(last_rx), 32'(v.exp_rx_data));
        chk($sformatf("v%0d_rx_data_held", i), 32'(rx_data), 32'(v.exp_rx_data));
      end
      chk($sformatf("v%0d_done", i),     32'(done), 32'(v.exp_done));
      chk($sformatf("v%0d_core_rst", i), 32'(core_rst), 32'(!v.exp_done));
      chk($sformatf("v%0d_err", i),      32'(err), 32'd0);
    end
    chk("addr_holds_last", 32'(mem_addr), 32'(MEM - 1));
`ifndef ICE51_LOADER_CHECKSUM_EN
    chk("release_after_last_we", 32'(fall_cyc), 32'(last_we_cyc + 1));
`endif

    // ---- line errors: glitch and framing error leave the count alone
    do_reset();
    mark();
    rx = 1'b0;
    repeat (24) @(negedge clk);   // ~2000 ns low glitch
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    $display("glitch: we=%0d", we_cnt - we_base);
    chk("glitch_no_we", 32'(we_cnt - we_base), 32'd0);
    mark();
    send_frame(8'hA5, 1'b0);
    $display("framing error 0xA5: we=%0d", we_cnt - we_base);
    chk("frame_err_no_we", 32'(we_cnt - we_base), 32'd0);
    chk("frame_err_no_rx", 32'(rxv_cnt - rxv_base), 32'd0);
    load_byte("after_err_33", 8'h33, 2'd0);
    load_byte("after_err_44", 8'h44, 2'd1);
    $display("after line errors: last write addr=%0d data=0x%02h", last_addr, last_wdata);

    // ---- reset mid-load restarts at address 0
    do_reset();
    chk("midrst_addr", 32'(mem_addr), 32'd0);
    chk("midrst_core_rst", 32'(core_rst), 32'd1);
    load_byte("re_11", 8'h11, 2'd0);
    load_byte("re_22", 8'h22, 2'd1);
    load_byte("re_33", 8'h33, 2'd2);
    chk("re_done_before_last", 32'(done), 32'd0);
    load_byte("re_44", 8'h44, 2'd3);
`ifdef ICE51_LOADER_CHECKSUM_EN
    mark();
    send_frame(8'hAA, 1'b1);
`endif
    $display("reload: done=%0d core_rst=%0d", done, core_rst);
    chk("re_done", 32'(done), 32'd1);
    chk("re_core_rst", 32'(core_rst), 32'd0);

`ifdef ICE51_LOADER_CHECKSUM_EN
    // ---- checksum: good, bad, then good again
    do_reset();
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    send_frame(8'h0A, 1'b1);
    $display("checksum 0x0A: done=%0d err=%0d", done, err);
    chk("ck_good_done", 32'(done), 32'd1);
    chk("ck_good_err", 32'(err), 32'd0);
    do_reset();
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    send_frame(8'h0B, 1'b1);
    $display("checksum 0x0B: done=%0d err=%0d", done, err);
    chk("ck_bad_err", 32'(err), 32'd1);
    chk("ck_bad_core_rst", 32'(core_rst), 32'd1);
    chk("ck_bad_done", 32'(done), 32'd0);
    load_byte("ck_retry_01", 8'h01, 2'd0);
    for (int i = 2; i <= 4; i++) send_frame(8'(i), 1'b1);
    chk("ck_err_sticky", 32'(err), 32'd1);
    send_frame(8'h0A, 1'b1);
    $display("checksum retry 0x0A: done=%0d err=%0d", done, err);
    chk("ck_retry_err", 32'(err), 32'd0);
    chk("ck_retry_done", 32'(done), 32'd1);
`endif

    chk("done_matches_not_core_rst", 32'(done_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ice51_boot_loader.md
# ice51_boot_loader

UART boot loader sitting between the board's serial input and the ice51 core's code memory. It deserialises 8N1 bytes from `i_uart_rx` and writes the first `MEM_SIZE` bytes sequentially into code memory from address 0, holding the core in reset while it does so. After loading completes, it releases the core and forwards every later received byte to the core's serial peripheral.

## Interface
Parameters:
- `CLKS_PER_BIT`, 104: clock cycles per UART bit (12 MHz / 115200).
- `MEM_SIZE`, 1024: number of bytes loaded into code memory.
- `ADDR_W`, 10: code memory address width; `2**ADDR_W >= MEM_SIZE`.

Ports:
- `i_clk`  in  1  system clock.
- `i_nrst`  in  1  reset, asynchronous, active-high.
- `i_uart_rx`  in  1  asynchronous serial input; idles high.
- `o_mem_we`  out  1  code memory write strobe, one cycle per byte.
- `o_mem_addr`  out  ADDR_W  code memory write address.
- `o_mem_wdata`  out  8  code memory write data.
- `o_core_rst`  out  1  active-high reset to the core; held while loading.
- `o_done`  out  1  load complete; core running.
- `o_err`  out  1  sticky checksum failure. Constant 0 without the macro.
- `o_rx_valid`  out  1  one-cycle pulse: post-boot byte available.
- `o_rx_data`  out  8  post-boot byte; held until the next pulse.

## Operation
- Reset values: `o_mem_we`=0, `o_mem_addr`=0, `o_mem_wdata`=0, `o_core_rst`=1, `o_done`=0, `o_err`=0, `o_rx_valid`=0, `o_rx_data`=0.
- The receive synchroniser is 2 flops; both reset to 1.

Receiver FSM:
- **IDLE**: waits for the synchronised input to go 1→0, then enters START with the bit counter cleared.
- **START**: after `CLKS_PER_BIT/2` cycles, samples the line. If it is 0, enters DATA. If it is 1, treats the edge as a glitch and returns to IDLE.
- **DATA**: samples 8 bits LSB-first, one every `CLKS_PER_BIT` cycles.
- **STOP**: samples one `CLKS_PER_BIT` later. If the line is 1, asserts an internal byte-valid pulse. If it is 0 (framing error), drops the byte silently. Either way, returns to IDLE in the same cycle so a new start edge can be detected immediately.

Loader FSM:
- **LOAD**: on each byte-valid, registers `o_mem_wdata`=byte and `o_mem_addr`=count, pulses `o_mem_we`, then increments count. When the write of count `MEM_SIZE-1` is issued, moves to RUN (or CHECK with the macro).
- **RUN**: `o_core_rst`=0 and `o_done`=1. Each byte-valid drives `o_rx_data` and pulses `o_rx_valid`. `o_mem_we` is never asserted again.
- Count is `ADDR_W+1` bits wide, so there is no wrap at `MEM_SIZE == 2**ADDR_W`.
- After the final write, `o_mem_addr` holds `MEM_SIZE-1`.
- Reset mid-byte or mid-load: everything returns to its reset value. Loading restarts at address 0 on the next complete byte. Partially written memory is simply overwritten.

## Timing
- Sampling point: the middle of each bit, i.e. `CLKS_PER_BIT/2 + n*CLKS_PER_BIT` cycles after the synchronised falling edge.
- Byte-valid is asserted in the cycle after the stop-bit sample.
- `o_mem_we`, `o_mem_addr` and `o_mem_wdata` are registered. The write strobe is high exactly 1 cycle, one cycle after byte-valid.
- `o_core_rst` falls and `o_done` rises in the same cycle. That is the cycle after the last `o_mem_we` pulse, or the cycle after the checksum byte-valid when the macro is enabled.
- `o_rx_valid` is asserted one cycle after byte-valid and lasts one cycle.
- Back-to-back frames are supported: a start bit immediately following the stop-bit midpoint is accepted.

## Configuration
- `ICE51_LOADER_CHECKSUM_EN` defined:
  - An 8-bit modular running sum covers all `MEM_SIZE` data bytes.
  - After the last data byte the loader enters CHECK, and the next received byte is compared with the sum.
  - Match: go to RUN and clear `o_err`.
  - Mismatch: set `o_err`=1, clear count and sum, return to LOAD, and keep `o_core_rst`=1.
  - `o_err` is cleared only by reset or a later successful check.
- `ICE51_LOADER_CHECKSUM_EN` undefined: no CHECK state and no sum register; `o_err` is tied 0.

## Test plan
- **Reset values**: assert `i_nrst` for 1000 ns with `i_uart_rx`=1 → all outputs at reset values; `o_core_rst`=1.
- **Basic load**: with `MEM_SIZE`=4, send 0x02,0x00,0x10,0xFF at 8681 ns/bit → 4 `o_mem_we` pulses with (addr,data) = (0,0x02),(1,0x00),(2,0x10),(3,0xFF). Then `o_core_rst`=0 and `o_done`=1.
- **Post-boot forwarding**: after load, send 0x5A → one `o_rx_valid` pulse with `o_rx_data`=0x5A; no further `o_mem_we`.
- **Line errors**: a 2000 ns low glitch, then a frame 0xA5 with stop bit 0 → no write and count unchanged. A following good 0x33 is written to address 0.
- **Checksum** (macro, `MEM_SIZE`=4): send 01,02,03,04,0x0A → RUN. Then reset, send 01,02,03,04,0x0B → `o_err`=1 and `o_core_rst`=1. Then send 01,02,03,04,0x0A → `o_err`=0 and `o_done`=1.
- **Reset mid-load**: assert reset after 2 of 4 bytes, then send 4 fresh bytes → writes start again at address 0 and `o_done` rises after the 4th.
